// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller sequencing one shared round datapath over NR rounds.
// Also carries a reference round datapath and AES-128 key store; abort input via AES_SEQ_ABORT_EN.

package aes_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (square-and-multiply), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = a;
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            p = gf_mul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
                 ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < 15; k++) begin
            if (k < n) r = xtime(r);
        end
        return r;
    endfunction

endpackage

module aes_mix_col (
    input  logic [31:0] i_col,
    input  logic        i_mix_en,
    output logic [31:0] o_col
);
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_mix;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_mix[31:24] = aes_pkg::xtime(w_a0) ^ aes_pkg::xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mix[23:16] = w_a0 ^ aes_pkg::xtime(w_a1) ^ aes_pkg::xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mix[15:8]  = w_a0 ^ w_a1 ^ aes_pkg::xtime(w_a2) ^ aes_pkg::xtime(w_a3) ^ w_a3;
    assign w_mix[7:0]   = aes_pkg::xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ aes_pkg::xtime(w_a3);

    assign o_col = i_mix_en ? w_mix : i_col;
endmodule

module aes_round_dp (
    input  logic [127:0] i_state,
    input  logic [127:0] i_rk,
    input  logic         i_mix_en,
    output logic [127:0] o_result
);
    localparam int NUM_COLS = 4;

    logic [7:0]  w_sb [16];
    logic [7:0]  w_sr [16];
    logic [31:0] w_mc [NUM_COLS];

    // Byte i sits at bits [127-8i -: 8]; byte index = row + 4*col.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign w_sb[i] = aes_pkg::sbox(i_state[127-8*i -: 8]);
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
        end
        aes_mix_col u_mix (
            .i_col    ({w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]}),
            .i_mix_en (i_mix_en),
            .o_col    (w_mc[c])
        );
    end

    assign o_result = {w_mc[0], w_mc[1], w_mc[2], w_mc[3]} ^ i_rk;
endmodule

module aes128_key_store (
    input  logic [127:0] i_key,
    input  logic [3:0]   i_round,
    output logic [127:0] o_rk
);
    logic [31:0]  w_w  [44];
    logic [127:0] w_rk [16];

    // Indices past round 10 have no AES-128 key and read as zero.
    always_comb begin
        for (int i = 0; i < 4; i++) w_w[i] = i_key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0)
                w_w[i] = w_w[i-4] ^ aes_pkg::sub_word({w_w[i-1][23:0], w_w[i-1][31:24]})
                       ^ {aes_pkg::rcon(i / 4), 24'h0};
            else
                w_w[i] = w_w[i-4] ^ w_w[i-1];
        end
        for (int r = 0; r < 11; r++) w_rk[r] = {w_w[4*r], w_w[4*r+1], w_w[4*r+2], w_w[4*r+3]};
        for (int r = 11; r < 16; r++) w_rk[r] = '0;
    end

    assign o_rk = w_rk[i_round];
endmodule

module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [3:0]   rk_round,
    input  logic [127:0] rk_key,
    output logic [127:0] dp_state,
    output logic         dp_mix_en,
    input  logic [127:0] dp_result,
    output logic         busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDK  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0]   r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic         w_last;
    logic         w_abort;

    assign w_last = (r_round == LAST_ROUND);

`ifdef AES_SEQ_ABORT_EN
    assign w_abort = abort & ((r_fsm == S_ADDK) | (r_fsm == S_ROUND));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= '0;
        end else if (w_abort) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: if (in_valid) begin
                    r_state <= in_block;
                    r_round <= '0;
                    r_fsm   <= S_ADDK;
                end
                // Initial whitening uses the key directly; dp_result is not valid here.
                S_ADDK: begin
                    r_state <= r_state ^ rk_key;
                    r_round <= 4'd1;
                    r_fsm   <= S_ROUND;
                end
                S_ROUND: begin
                    r_state <= dp_result;
                    if (w_last) r_fsm <= S_DONE;
                    else        r_round <= r_round + 4'd1;
                end
                S_DONE: if (out_ready) begin
                    r_fsm   <= S_IDLE;
                    r_round <= '0;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_block = r_state;
    assign dp_state  = r_state;
    assign rk_round  = (r_fsm == S_ROUND) ? r_round : 4'd0;
    assign dp_mix_en = (r_fsm == S_ROUND) & ~w_last;
endmodule
